strobe_decoder: RTL
===================

Name: strobe_decoder

Overview:
- Registered binary-to-one-hot decoder with a valid/ready input handshake.
- Each accepted code becomes a one-hot strobe held for HOLD cycles, followed by a GAP-cycle quiet period.
- Converts binary indices back into one-hot select/strobe lines.
- Sits at the consuming end of one-hot-to-binary encoded paths.

Parameters:
- IN_SIZE, 4, width of the binary code input.
- OUT_SIZE, 1<<IN_SIZE, localparam, width of the one-hot output.
- HOLD, 2, cycles the one-hot strobe stays asserted per code; legal range 1..255.
- GAP, 1, forced idle cycles after each strobe; legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  block enable; low blocks acceptance and aborts an active strobe.
- in_valid  input  1  code present on in.
- in_ready  output  1  block can accept a code this cycle.
- in  input  IN_SIZE  binary code to decode.
- out  output  OUT_SIZE  registered one-hot strobe.
- out_valid  output  1  high exactly while out is non-zero.
- busy  output  1  high in DRIVE or GAP state.

Behaviour:
- Reset values: out=0, out_valid=0, busy=0, state=IDLE, hold/gap counter=0.
- in_ready is 0 during any cycle with rst high.
- States: IDLE, DRIVE, GAP. The counter is 8 bits.
- in_ready is combinational: 1 iff state==IDLE && enable && !rst. It never depends on in_valid.
- Accept means in_valid && in_ready at a rising edge.
- IDLE -> DRIVE on accept. At that edge: out <= 1<<in, out_valid <= 1, counter <= HOLD-1. Latency from accept edge to strobe visible is 1 cycle.
- Every code 0..OUT_SIZE-1 is legal. Exactly one bit of out is high in DRIVE.
- DRIVE while counter != 0: counter decrements; out is held stable.
- DRIVE with counter == 0:
  - If GAP > 0: -> GAP, out <= 0, out_valid <= 0, counter <= GAP-1.
  - If GAP == 0: -> IDLE, out <= 0.
- GAP: out = 0; counter decrements. At counter == 0 -> IDLE.
- Sustained throughput: one code per 1+HOLD+GAP cycles.
- Strobe width is exactly HOLD cycles. Gap width is exactly GAP cycles.
- enable low in DRIVE or GAP: next edge -> IDLE, out <= 0, out_valid <= 0, counter <= 0. The abort is silent; the code is dropped.
- enable low in IDLE: no acceptance; in_valid is ignored and the code is not stored.
- rst high in any state: next edge restores all reset values. An accepted code in flight is discarded.
- rst and accept conditions in the same cycle: rst wins; in_ready is already 0.
- in is sampled only on the accept edge. Changes to in during DRIVE/GAP have no effect.
- busy = (state != IDLE), registered with state.

Optional Feature:
- Macro STROBE_DECODER_PARITY_EN.
- Defined:
  - Adds input in_parity (1 bit, even parity over in) and output err (1 bit, reset 0).
  - On accept with a parity mismatch: handshake completes, no strobe is issued, state stays IDLE.
  - err pulses high for exactly 1 cycle, the cycle after the accept edge.
  - Correct parity behaves exactly as the base block, with err=0.
- Undefined:
  - in_parity and err are absent.
  - Every accepted code is strobed.

Test Plan:
- IN_SIZE=4, HOLD=2, GAP=1 unless stated.
- Reset: rst high 2 cycles with in_valid=1, in=5 -> out=0, out_valid=0, busy=0, in_ready=0. After release with enable=1 -> in_ready=1.
- Single code: accept in=9 at edge T -> out=16'h0200 on cycles T+1 and T+2. Then out=0 and busy=1 on T+3. Then in_ready=1 on T+4.
- Back-to-back: in_valid held with codes 0, then 15 -> out=16'h0001 for 2 cycles, 0 for 1 cycle, in_ready=1 for 1 cycle, then 16'h8000 for 2 cycles. in_ready=0 during DRIVE/GAP.
- Abort: accept in=3, drop enable on the first DRIVE cycle -> next cycle out=0, state IDLE. in_ready stays 0 until enable returns, then becomes 1.
- Reset mid-strobe: accept in=7, assert rst on first DRIVE cycle -> next cycle out=0, busy=0. No residual strobe after rst release.
- Parity (STROBE_DECODER_PARITY_EN defined): in=3, in_parity=1 -> accepted, out stays 0, err=1 for one cycle, in_ready=1 the next cycle. in=3, in_parity=0 -> normal strobe 16'h0008, err=0.

Source files
------------

// File: rtl/strobe_decoder.sv
// strobe_decoder: registered binary-to-one-hot decoder with a valid/ready
// input handshake. Each accepted code is driven as a one-hot strobe for HOLD
// cycles and is then followed by a GAP-cycle quiet period.
//
// Optional feature macro: STROBE_DECODER_PARITY_EN
//   When defined, adds an even-parity input (in_parity) and a one-cycle error
//   pulse (err). A code with bad parity completes the handshake but is not
//   strobed.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a code; in_ready high when enabled
// DRIVE | one-hot strobe asserted; counter counts remaining hold cycles
// GAP   | forced quiet period; counter counts remaining gap cycles

module strobe_decoder #(
  parameter int IN_SIZE = 4,
  parameter int HOLD    = 2,
  parameter int GAP     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_SIZE-1:0]        in,
`ifdef STROBE_DECODER_PARITY_EN
  input  logic                      in_parity,
  output logic                      err,
`endif
  output logic [(1<<IN_SIZE)-1:0]   out,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int OUT_SIZE = 1 << IN_SIZE;

  // The counter holds "cycles remaining minus one", so a zero count means the
  // current cycle is the last one of the strobe or gap.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);
  localparam logic [OUT_SIZE-1:0] ONE = {{(OUT_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP_S = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] count;

  // Ready depends only on state, enable and reset, never on in_valid.
  assign in_ready = (state == IDLE) && enable && !rst;

  // Single-process FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef STROBE_DECODER_PARITY_EN
      err       <= 1'b0;
`endif
    end else begin
`ifdef STROBE_DECODER_PARITY_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid && enable) begin
`ifdef STROBE_DECODER_PARITY_EN
            if (in_parity != ^in) begin
              // Bad code: handshake completes, nothing is strobed.
              err <= 1'b1;
            end else begin
              state     <= DRIVE;
              out       <= ONE << in;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              count     <= HOLD_LOAD;
            end
`else
            state     <= DRIVE;
            out       <= ONE << in;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            count     <= HOLD_LOAD;
`endif
          end
        end

        DRIVE: begin
          if (!enable) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= 8'd0;
          end else if (count != 8'd0) begin
            count <= count - 8'd1;
          end else if (GAP > 0) begin
            state     <= GAP_S;
            out       <= '0;
            out_valid <= 1'b0;
            count     <= GAP_LOAD;
          end else begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= 8'd0;
          end
        end

        GAP_S: begin
          if (!enable || count == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= 8'd0;
          end else begin
            count <= count - 8'd1;
          end
        end

        default: begin
          state     <= IDLE;
          out       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          count     <= 8'd0;
        end
      endcase
    end
  end

endmodule
